// File: rtl/lc3b_types.sv
// Shared LC-3b word/mask types and data-memory responder FSM encoding.
// Any responder latency or backpressure comes from the modules that import these.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } dmem_resp_state_t;

  localparam int DMEM_WAIT_DEFAULT = 2;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with per-byte write enables; synchronous write, asynchronous read.
// Zero-latency read, one-edge write, no backpressure.
module dmem_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  lc3b_mem_wmask        be_i,
  input  logic [ADDR_BITS-1:0] widx_i,
  input  lc3b_word             wdata_i,
  input  logic [ADDR_BITS-1:0] ridx_i,
  output lc3b_word             rdata_o
);

  lc3b_word mem_q [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      if (be_i[0]) mem_q[widx_i][7:0]  <= wdata_i[7:0];
      if (be_i[1]) mem_q[widx_i][15:8] <= wdata_i[15:8];
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/dmem_responder.sv
// Strobe/cycle data-memory responder: resp pulses WAIT_STATES+1 cycles after a request is seen in IDLE;
// dropping cyc aborts the request. Optional access counters under DMEM_ACCESS_COUNT_EN.
module dmem_responder
  import lc3b_types::*;
#(
  parameter int WAIT_STATES = DMEM_WAIT_DEFAULT,
  parameter int ADDR_BITS   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dmem_action_stb,
  input  logic          dmem_action_cyc,
  input  logic          dmem_write,
  input  lc3b_mem_wmask dmem_byte_enable,
  input  lc3b_word      dmem_address,
  input  lc3b_word      dmem_wdata,
`ifdef DMEM_ACCESS_COUNT_EN
  output logic [15:0]   dmem_read_count,
  output logic [15:0]   dmem_write_count,
`endif
  output lc3b_word      dmem_rdata,
  output logic          dmem_resp
);

  localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  dmem_resp_state_t     state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 write_q, write_d;
  lc3b_mem_wmask        be_q, be_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  lc3b_word             wdata_q, wdata_d;
  lc3b_word             rdata_q, rdata_d;

  logic                 req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] addr_idx;
  logic [ADDR_BITS-1:0] rd_idx;
  lc3b_word             rd_word;
  logic                 unused_addr_bits;

  assign req              = dmem_action_stb & dmem_action_cyc;
  assign addr_idx         = dmem_address[ADDR_BITS:1];
  assign unused_addr_bits = ^{dmem_address[15:ADDR_BITS+1], dmem_address[0]};
  // With zero wait states ACK is entered straight from IDLE, before idx_q is latched.
  assign rd_idx           = (state_q == IDLE) ? addr_idx : idx_q;

  dmem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .be_i   (be_q),
    .widx_i (idx_q),
    .wdata_i(wdata_q),
    .ridx_i (rd_idx),
    .rdata_o(rd_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    be_d    = be_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          write_d = dmem_write & (|dmem_byte_enable);
          be_d    = dmem_byte_enable;
          idx_d   = addr_idx;
          wdata_d = dmem_wdata;
          if (WAIT_STATES == 0) begin
            state_d = ACK;
            rdata_d = rd_word;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (!dmem_action_cyc) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          rdata_d = rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        mem_we  = write_q & req;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      be_q    <= 2'b00;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmem_resp  = (state_q == ACK) & req;
  assign dmem_rdata = rdata_q;

`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (dmem_resp) begin
      if (write_q && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      if (!write_q && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign dmem_read_count  = rd_cnt_q;
  assign dmem_write_count = wr_cnt_q;
`endif

endmodule
